// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - byte-serial framed boot loader writing instruction memory
// Holds the core in reset until a length-framed, XOR-checksummed image has been written.
module imem_program_loader #(
    parameter int          MAX_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 100000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   asm_q, asm_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [15:0]   len_new;

    assign len_new = {byte_data, len_q[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            chk_q   <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        chk_d   = chk_q;
        tmo_d   = '0;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        // Address advances the cycle after each write pulse.
        addr_d  = we_q ? addr_q + 32'd4 : addr_q;

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    state_d = S_LEN0;
                    chk_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    addr_d  = BASE_ADDR;
                end
            end
            S_LEN0: begin
                if (byte_valid) begin
                    len_d[7:0] = byte_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (byte_valid) begin
                    len_d = len_new;
                    if (32'(len_new) > 32'(MAX_WORDS)) begin
                        state_d = S_ERROR;
                    end else if (len_new == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (byte_valid) begin
                    asm_d[{idx_q, 3'b000} +: 8] = byte_data;
                    chk_d = chk_q ^ byte_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {byte_data, asm_q[23:0]};
                        cnt_d   = cnt_q + 16'd1;
                        if (cnt_q + 16'd1 == len_q) begin
                            state_d = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (byte_valid) begin
                    state_d = (byte_data == chk_q) ? S_DONE : S_ERROR;
                end
            end
            default: ;
        endcase

        // Inter-byte idle watchdog while a frame is in progress.
        if (state_q inside {S_LEN0, S_LEN1, S_DATA, S_CHK} && !byte_valid) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d = S_ERROR;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - scoreboard bench for imem_program_loader
module tb_imem_program_loader;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic [31:0] wbuf[0:7];

    imem_program_loader #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h required=no_write", imem_addr, imem_wdata);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                             imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] chk, input int gap);
        send(8'hA5);          idle(gap);
        send(8'(n));          idle(gap);
        send(8'(n >> 8));     idle(gap);
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 4; b++) begin
                logic [31:0] w;
                w = wbuf[k];
                send(w[8*b +: 8]);
                if (b == 3) sb.push_back({32'(4 * k), w});
                idle(gap);
            end
        end
        send(chk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic cr);
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_err"}, 32'(err), 32'(e));
        check({tag, "_core_rst"}, 32'(core_rst), 32'(cr));
    endtask

    task automatic load_a();
        wbuf[0] = 32'h00A00513;
        wbuf[1] = 32'h00100593;
    endtask

    initial begin
        #1;
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check_status("rst", 1'b0, 1'b0, 1'b1);
        idle(2);
        rst = 1'b0;
        idle(1);

        // Garbage then good frame; later bytes ignored.
        load_a();
        send(8'h00); send(8'hFF); send(8'h5A);
        send_frame(2, 8'h30, 0);
        idle(1);
        check_status("good", 1'b1, 1'b0, 1'b0);
        send(8'hA5); send(8'h02); send(8'h00);
        for (int i = 0; i < 8; i++) send(8'h13);
        idle(3);
        check_status("after_done", 1'b1, 1'b0, 1'b0);

        // Bad checksum then recovery.
        do_reset();
        send_frame(2, 8'h00, 0);
        idle(1);
        check_status("badchk", 1'b0, 1'b1, 1'b1);
        send_frame(2, 8'h30, 0);
        idle(1);
        check_status("recover_chk", 1'b1, 1'b0, 1'b0);

        // Oversized length, then a slow but in-budget frame.
        do_reset();
        send(8'hA5); send(8'h01); send(8'h04);
        check_status("len_big", 1'b0, 1'b1, 1'b1);
        send_frame(2, 8'h30, TMO - 1);
        idle(1);
        check_status("slow_ok", 1'b1, 1'b0, 1'b0);

        // Stall after second data byte.
        do_reset();
        send(8'hA5); send(8'h02); send(8'h00); send(8'h13); send(8'h05);
        idle(TMO + 5);
        check_status("timeout", 1'b0, 1'b1, 1'b1);
        send_frame(2, 8'h30, 0);
        idle(1);
        check_status("recover_tmo", 1'b1, 1'b0, 1'b0);

        // Empty image.
        do_reset();
        send_frame(0, 8'h00, 0);
        idle(1);
        check_status("empty", 1'b1, 1'b0, 1'b0);

        // Three words back-to-back.
        do_reset();
        wbuf[0] = 32'h11223344;
        wbuf[1] = 32'hDEADBEEF;
        wbuf[2] = 32'h0BADF00D;
        send_frame(3, 8'h3D, 0);
        idle(1);
        check_status("b2b", 1'b1, 1'b0, 1'b0);

        // Reset asserted while the second word's write pulse is high.
        do_reset();
        send(8'hA5); send(8'h03); send(8'h00);
        send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        sb.push_back({32'h0, 32'h11223344});
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        check("pre_rst_we", 32'(imem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("async_we", 32'(imem_we), 32'd0);
        check("async_addr", imem_addr, 32'h0);
        check("async_wdata", imem_wdata, 32'h0);
        check_status("async", 1'b0, 1'b0, 1'b1);
        idle(2);
        rst = 1'b0;
        idle(1);
        send(8'h00); send(8'h00); send(8'h00);
        check_status("idle_after_rst", 1'b0, 1'b0, 1'b1);
        load_a();
        send_frame(2, 8'h30, 0);
        idle(2);
        check_status("final", 1'b1, 1'b0, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired required=finish");
        $fatal(1);
    end

endmodule
